// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end: scan codes, ASCII
// constants, decoder states and the frame parity helper.
package ps2_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_SPACE  = 8'h29;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } dec_state_t;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scan-code set 2 to ASCII lookup, purely combinational so the same table can
// serve both the receiver and a keyboard model.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       hit
);

    logic [7:0]  lower;
    logic [15:0] pair;
    logic [7:0]  fixed;

    // Exactly one of lower / pair / fixed is non-zero for a mapped code.
    always_comb begin
        lower = 8'h00;
        pair  = 16'h0000;
        fixed = 8'h00;
        case (code)
            8'h1C: lower = "a";
            8'h32: lower = "b";
            8'h21: lower = "c";
            8'h23: lower = "d";
            8'h24: lower = "e";
            8'h2B: lower = "f";
            8'h34: lower = "g";
            8'h33: lower = "h";
            8'h43: lower = "i";
            8'h3B: lower = "j";
            8'h42: lower = "k";
            8'h4B: lower = "l";
            8'h3A: lower = "m";
            8'h31: lower = "n";
            8'h44: lower = "o";
            8'h4D: lower = "p";
            8'h15: lower = "q";
            8'h2D: lower = "r";
            8'h1B: lower = "s";
            8'h2C: lower = "t";
            8'h3C: lower = "u";
            8'h2A: lower = "v";
            8'h1D: lower = "w";
            8'h22: lower = "x";
            8'h35: lower = "y";
            8'h1A: lower = "z";
            8'h16: pair = "1!";
            8'h1E: pair = "2@";
            8'h26: pair = "3#";
            8'h25: pair = "4$";
            8'h2E: pair = "5%";
            8'h36: pair = "6^";
            8'h3D: pair = "7&";
            8'h3E: pair = "8*";
            8'h46: pair = "9(";
            8'h45: pair = "0)";
            8'h0E: pair = "`~";
            8'h4E: pair = "-_";
            8'h55: pair = "=+";
            8'h54: pair = "[{";
            8'h5B: pair = "]}";
            8'h5D: pair = {8'h5C, 8'h7C};
            8'h4C: pair = ";:";
            8'h52: pair = {8'h27, 8'h22};
            8'h41: pair = ",<";
            8'h49: pair = ".>";
            8'h4A: pair = "/?";
            SC_ENTER: fixed = ASCII_LF;
            SC_SPACE: fixed = ASCII_SPACE;
            SC_BKSP:  fixed = ASCII_BS;
            default: ;
        endcase
    end

    always_comb begin
        ascii = fixed;
        hit   = 1'b0;
        if (lower != 8'h00) begin
            ascii = (shift ^ caps) ? (lower - 8'h20) : lower;
            hit   = 1'b1;
        end else if (pair != 16'h0000) begin
            ascii = shift ? pair[7:0] : pair[15:8];
            hit   = 1'b1;
        end else if (fixed != 8'h00) begin
            hit   = 1'b1;
        end
    end

endmodule

// File: rtl/ps2_ascii.sv
// PS/2 keyboard receiver and make/break decoder producing one ASCII strobe per
// key press for the text terminal.
module ps2_ascii
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_out,
    output logic       p_valid,
    output logic       frame_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    logic              clk_s1, clk_s2, clk_s3;
    logic              data_s1, data_s2;
    logic              fall;
    logic [3:0]        bitcnt;
    logic [IDLE_W-1:0] idle;
    logic              stale;
    logic [9:0]        sr;
    logic              start_bit;
    logic              vld_p0;
    logic [7:0]        code;
    logic              frame_ok;
    logic [7:0]        ascii;
    logic              hit;
    logic              shift;
    logic              caps;
    dec_state_t        state;

    // Synchroniser: the keyboard pins are asynchronous, so they carry no reset.
    always_ff @(posedge clk) begin
        clk_s1  <= ps2_clk;
        clk_s2  <= clk_s1;
        clk_s3  <= clk_s2;
        data_s1 <= ps2_data;
        data_s2 <= data_s1;
    end

    assign fall  = clk_s3 & ~clk_s2;
    assign stale = (bitcnt != 4'd0) && (idle == IDLE_MAX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bitcnt <= 4'd0;
            idle   <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (fall) begin
                idle <= '0;
                if (bitcnt == 4'd10) begin
                    bitcnt <= 4'd0;
                    vld_p0 <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 4'd1;
                end
            end else begin
                if (idle != IDLE_MAX)
                    idle <= idle + IDLE_W'(1);
                if (stale)
                    bitcnt <= 4'd0;
            end
        end
    end

    // Start bit kept apart; sr ends up as {stop, parity, data[7:0]}.
    always_ff @(posedge clk) begin
        if (fall) begin
            if (bitcnt == 4'd0)
                start_bit <= data_s2;
            else
                sr <= {data_s2, sr[9:1]};
        end else if (stale) begin
            sr <= '0;
        end
    end

    // ---- stage p0 -> output: frame check, decode and registered strobes ----
    assign code     = sr[7:0];
    assign frame_ok = !start_bit && sr[9] && parity_ok(sr[8:0]);

    ps2_keymap u_keymap (
        .code  (code),
        .shift (shift),
        .caps  (caps),
        .ascii (ascii),
        .hit   (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_NORMAL;
            shift     <= 1'b0;
            caps      <= 1'b0;
            key_out   <= 8'h00;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
            if (vld_p0) begin
                if (!frame_ok) begin
                    frame_err <= 1'b1;
                end else begin
                    case (state)
                        ST_NORMAL: begin
                            if (code == SC_BREAK)
                                state <= ST_BREAK;
                            else if (code == SC_EXT)
                                state <= ST_EXT;
                            else if (code == SC_LSHIFT || code == SC_RSHIFT)
                                shift <= 1'b1;
                            else if (code == SC_CAPS)
                                caps <= ~caps;
                            else if (hit) begin
                                key_out <= ascii;
                                p_valid <= 1'b1;
                            end
                        end
                        ST_BREAK: begin
                            if (code == SC_LSHIFT || code == SC_RSHIFT)
                                shift <= 1'b0;
                            state <= ST_NORMAL;
                        end
                        ST_EXT:
                            state <= (code == SC_BREAK) ? ST_EXT_BREAK : ST_NORMAL;
                        ST_EXT_BREAK:
                            state <= ST_NORMAL;
                        default:
                            state <= ST_NORMAL;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii.sv
// Randomised bench for ps2_ascii: frames are bit-banged on the PS/2 pins, a
// key-level model queues the expected strobes and a monitor checks them.
module tb_ps2_ascii;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_out;
    logic       p_valid;
    logic       frame_err;

    ps2_ascii #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_out   (key_out),
        .p_valid   (p_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] key;
        int         at;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Key tables, built from character strings rather than per-code cases.
    logic [7:0] unsh [256];
    logic [7:0] shf  [256];
    bit         is_letter [256];
    bit         mapped [256];
    logic [7:0] lcodes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] scodes [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A};
    logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h16, 8'h1E, 8'h45, 8'h4E, 8'h52,
                              8'h5A, 8'h29, 8'h66, 8'h12, 8'h59, 8'h58, 8'hF0, 8'hE0, 8'h75,
                              8'h05, 8'h76};

    // Keyboard state as the user sees it.
    bit m_shift, m_caps, m_break, m_ext, m_skip;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic build_tables();
        string lo_s, hi_s;
        lo_s = "1234567890`-=[]#;',./";
        hi_s = "!@#$%^&*()~_+{}|:#<>?";
        lo_s.putc(15, 8'h5C);
        hi_s.putc(17, 8'h22);
        for (int i = 0; i < 256; i++) begin
            unsh[i] = 8'h00; shf[i] = 8'h00; is_letter[i] = 0; mapped[i] = 0;
        end
        for (int i = 0; i < 26; i++) begin
            unsh[lcodes[i]] = 8'h61 + 8'(i);
            shf[lcodes[i]]  = 8'h41 + 8'(i);
            is_letter[lcodes[i]] = 1;
            mapped[lcodes[i]] = 1;
        end
        for (int i = 0; i < 21; i++) begin
            unsh[scodes[i]] = lo_s[i];
            shf[scodes[i]]  = hi_s[i];
            mapped[scodes[i]] = 1;
        end
        unsh[8'h5A] = 8'd10; shf[8'h5A] = 8'd10; mapped[8'h5A] = 1;
        unsh[8'h29] = 8'd32; shf[8'h29] = 8'd32; mapped[8'h29] = 1;
        unsh[8'h66] = 8'd8;  shf[8'h66] = 8'd8;  mapped[8'h66] = 1;
    endtask

    task automatic model_reset();
        m_shift = 0; m_caps = 0; m_break = 0; m_ext = 0; m_skip = 0;
    endtask

    task automatic model(input logic [7:0] c, output bit emit, output logic [7:0] ch);
        emit = 0;
        ch = 8'h00;
        if (m_ext) begin
            m_ext = 0;
            if (c == 8'hF0) m_skip = 1;
        end else if (m_skip) begin
            m_skip = 0;
        end else if (m_break) begin
            m_break = 0;
            if (c == 8'h12 || c == 8'h59) m_shift = 0;
        end else if (c == 8'hF0) m_break = 1;
        else if (c == 8'hE0) m_ext = 1;
        else if (c == 8'h12 || c == 8'h59) m_shift = 1;
        else if (c == 8'h58) m_caps = !m_caps;
        else if (mapped[c]) begin
            emit = 1;
            if (is_letter[c]) ch = (m_shift ^ m_caps) ? shf[c] : unsh[c];
            else ch = m_shift ? shf[c] : unsh[c];
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // kind: 0 nothing expected, 1 key strobe, 2 frame error
    task automatic send_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop,
                              input int first, input int last, input int kind,
                              input logic [7:0] key);
        logic [10:0] b;
        exp_t e;
        b = {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
        for (int i = first; i <= last; i++) begin
            ps2_data = b[i];
            tick($urandom_range(2, 4));
            if (i == 10 && kind != 0) begin
                e.err = (kind == 2);
                e.key = key;
                e.at  = cyc + 4;
                q.push_back(e);
            end
            ps2_clk = 1'b0;
            tick($urandom_range(3, 8));
            ps2_clk = 1'b1;
            tick($urandom_range(3, 8));
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_key(input logic [7:0] c);
        bit emit;
        logic [7:0] ch;
        model(c, emit, ch);
        send_frame(c, 1'b0, 1'b0, 0, 10, emit ? 1 : 0, ch);
        tick($urandom_range(2, 20));
    endtask

    task automatic send_bad(input logic [7:0] c, input bit bad_par, input bit bad_stop);
        send_frame(c, bad_par, bad_stop, 0, 10, 2, 8'h00);
        tick($urandom_range(2, 20));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check(name, q.size(), 0);
        q.delete();
    endtask

    // Monitor: every output event must match the head of the queue.
    bit         rst_seen = 1'b0;
    logic [7:0] last_key = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                check("reset_key_out", key_out, 8'h00);
                check("reset_p_valid", p_valid, 1'b0);
                check("reset_frame_err", frame_err, 1'b0);
                last_key = 8'h00;
                rst_seen = 1'b0;
            end
            if (p_valid && frame_err)
                check("pv_fe_exclusive", {p_valid, frame_err}, 2'b10);
            if (p_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_out", {p_valid, frame_err, key_out}, 10'h0);
                end else begin
                    e = q.pop_front();
                    check("event_kind", frame_err, e.err);
                    check("latency", cyc, e.at);
                    if (!e.err) begin
                        check("key_out", key_out, e.key);
                        last_key = e.key;
                    end else begin
                        check("key_hold_err", key_out, last_key);
                    end
                end
            end else begin
                check("key_hold", key_out, last_key);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_tables();
        model_reset();
        reset = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(5);

        // Basic press and release.
        send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        drain("drain_basic");

        // Shift and caps interaction.
        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h12); send_key(8'h1C);
        send_key(8'h58); send_key(8'hF0); send_key(8'h58); send_key(8'h16);
        send_key(8'h12); send_key(8'h16); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12); send_key(8'h58); send_key(8'hF0); send_key(8'h58);
        drain("drain_shift_caps");

        // Control keys and extended keys.
        send_key(8'h5A); send_key(8'h29); send_key(8'h66);
        send_key(8'hE0); send_key(8'h75); send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        send_key(8'h1C);
        drain("drain_special");

        // Rejected frames.
        send_bad(8'h1C, 1'b1, 1'b0);
        send_bad(8'h1C, 1'b0, 1'b1);
        send_key(8'h32);
        drain("drain_bad");

        // Partial frame abandoned by the idle timeout.
        send_frame(8'h1C, 1'b0, 1'b0, 0, 4, 0, 8'h00);
        tick(TO + 5);
        send_key(8'h1C);
        drain("drain_timeout");

        // Reset mid-frame with caps on and a break prefix pending.
        send_key(8'h58); send_key(8'h1C); send_key(8'hF0);
        drain("drain_pre_reset");
        send_frame(8'h1C, 1'b0, 1'b0, 0, 4, 0, 8'h00);
        reset = 1'b0;
        model_reset();
        tick(1);
        reset = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b0, 5, 10, 0, 8'h00);
        tick(TO + 30);
        send_key(8'h1C);
        drain("drain_post_reset");

        // Random key traffic with occasional corrupted frames.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0)
                send_bad(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            else
                send_key(pool[$urandom_range(0, 19)]);
        end
        drain("drain_random");

        tick(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
